// File: rtl/decomp_pkg.sv
`default_nettype none
// decomp_pkg: shared types and header field positions for the compressed fetch stage.
// Rev 1.0
package decomp_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    HDR        = 3'd1,
    RAWF       = 3'd2,
    RAWD       = 3'd3,
    EMIT_FIRST = 3'd4,
    EMIT_LAST  = 3'd5,
    HALT       = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    HDR_RAW    = 2'b00,
    HDR_SINGLE = 2'b01,
    HDR_PAIR   = 2'b10,
    HDR_END    = 2'b11
  } hdr_type_t;

  localparam int c_HDR_TYPE_HI = 31;
  localparam int c_HDR_TYPE_LO = 30;
  localparam int c_TOK_A_HI    = 15;
  localparam int c_TOK_A_LO    = 8;
  localparam int c_TOK_B_HI    = 7;
  localparam int c_TOK_B_LO    = 0;

endpackage
`default_nettype wire

// File: rtl/decomp_fetch_unit_if.sv
`default_nettype none
// decomp_fetch_unit_if: compressed-memory, token-table, decoder and redirect signals.
// Rev 1.0
interface decomp_fetch_unit_if #(
  parameter int WIDTH = 32,
  parameter int TOKW  = 8
);
  logic             cmem_rd;
  logic [WIDTH-1:0] cmem_addr;
  logic [WIDTH-1:0] cmem_rdata;
  logic [TOKW-1:0]  tok_idx;
  logic [WIDTH-1:0] tok_data;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect;
  logic [WIDTH-1:0] redirect_caddr;
  logic [WIDTH-1:0] redirect_pc;
  logic             halted;

  modport master (
    output cmem_rd, cmem_addr, tok_idx, instr, instr_pc, instr_valid, halted,
    input  cmem_rdata, tok_data, instr_ready, redirect, redirect_caddr, redirect_pc
  );

  modport slave (
    input  cmem_rd, cmem_addr, tok_idx, instr, instr_pc, instr_valid, halted,
    output cmem_rdata, tok_data, instr_ready, redirect, redirect_caddr, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/decomp_hdr_decode.sv
`default_nettype none
// decomp_hdr_decode: splits a header word into its type and two token indices.
// Rev 1.0
module decomp_hdr_decode
  import decomp_pkg::*;
#(
  parameter int TOKW = 8
) (
  input  logic [31:0]     i_word,
  output hdr_type_t       o_type,
  output logic [TOKW-1:0] o_tok_a,
  output logic [TOKW-1:0] o_tok_b
);

  logic w_unused_bits;

  assign o_type  = hdr_type_t'(i_word[c_HDR_TYPE_HI:c_HDR_TYPE_LO]);
  assign o_tok_a = TOKW'(i_word[c_TOK_A_HI:c_TOK_A_LO]);
  assign o_tok_b = TOKW'(i_word[c_TOK_B_HI:c_TOK_B_LO]);

  assign w_unused_bits = ^i_word[c_HDR_TYPE_LO-1:c_TOK_A_HI+1];

endmodule
`default_nettype wire

// File: rtl/decomp_fetch_unit.sv
`default_nettype none
// decomp_fetch_unit: reads compressed words, expands tokens and hands instructions to the decoder.
// Rev 1.0
module decomp_fetch_unit
  import decomp_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               TOKW       = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                reset,
  decomp_fetch_unit_if.master bus
);

  localparam logic [WIDTH-1:0] c_ADDR_MASK  = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] c_STEP       = WIDTH'(4);
  localparam logic [WIDTH-1:0] c_RESET_ADDR = RESET_ADDR & c_ADDR_MASK;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_instr, w_instr_nxt;
  logic [WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_halted, w_halted_nxt;
  logic [TOKW-1:0]  r_tok_b, w_tok_b_nxt;
  logic [TOKW-1:0]  w_tok_idx;
  logic             w_hs;
  logic             w_unused_caddr;

  hdr_type_t        w_type;
  logic [TOKW-1:0]  w_tok_a;
  logic [TOKW-1:0]  w_tok_b;

  decomp_hdr_decode #(
    .TOKW (TOKW)
  ) u_hdr_decode (
    .i_word  (bus.cmem_rdata[31:0]),
    .o_type  (w_type),
    .o_tok_a (w_tok_a),
    .o_tok_b (w_tok_b)
  );

  assign w_hs           = r_valid & bus.instr_ready;
  assign w_unused_caddr = ^bus.redirect_caddr[1:0];

  // Read strobe is masked during reset so nothing is fetched while state is forced.
  assign bus.cmem_rd     = ~reset & ((r_state == FETCH) | (r_state == RAWF));
  assign bus.cmem_addr   = r_addr;
  assign bus.tok_idx     = w_tok_idx;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;

  always_comb begin
    w_tok_idx = '0;
    case (r_state)
      HDR:        w_tok_idx = (w_type == HDR_PAIR) ? w_tok_a : w_tok_b;
      EMIT_FIRST: w_tok_idx = r_tok_b;
      default:    w_tok_idx = '0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_halted_nxt   = r_halted;
    w_tok_b_nxt    = r_tok_b;

    case (r_state)
      FETCH: w_state_nxt = HDR;
      HDR: begin
        w_tok_b_nxt = w_tok_b;
        case (w_type)
          HDR_RAW: begin
            w_addr_nxt  = r_addr + c_STEP;
            w_state_nxt = RAWF;
          end
          HDR_SINGLE, HDR_PAIR: begin
            w_instr_nxt = bus.tok_data;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = r_addr + c_STEP;
            w_state_nxt = (w_type == HDR_PAIR) ? EMIT_FIRST : EMIT_LAST;
          end
          default: begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = HALT;
          end
        endcase
      end
      RAWF: w_state_nxt = RAWD;
      RAWD: begin
        w_instr_nxt = bus.cmem_rdata;
        w_valid_nxt = 1'b1;
        w_addr_nxt  = r_addr + c_STEP;
        w_state_nxt = EMIT_LAST;
      end
      EMIT_FIRST: begin
        if (w_hs) begin
          w_pc_nxt       = r_pc + c_STEP;
          w_instr_pc_nxt = r_pc + c_STEP;
          w_instr_nxt    = bus.tok_data;
          w_state_nxt    = EMIT_LAST;
        end
      end
      EMIT_LAST: begin
        if (w_hs) begin
          w_pc_nxt       = r_pc + c_STEP;
          w_instr_pc_nxt = r_pc + c_STEP;
          w_valid_nxt    = 1'b0;
          w_state_nxt    = FETCH;
        end
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase

    // Redirect wins over any handshake; in-flight read data is simply not consumed.
    if (bus.redirect) begin
      w_state_nxt    = FETCH;
      w_valid_nxt    = 1'b0;
      w_halted_nxt   = 1'b0;
      w_addr_nxt     = bus.redirect_caddr & c_ADDR_MASK;
      w_pc_nxt       = bus.redirect_pc;
      w_instr_pc_nxt = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_addr     <= c_RESET_ADDR;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_tok_b    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halted   <= w_halted_nxt;
      r_tok_b    <= w_tok_b_nxt;
    end
  end

endmodule
`default_nettype wire
